// File: rtl/wb_scoreboard_arb_if.sv
// wb_scoreboard_arb_if
//   Groups the signals of the write-back arbiter / scoreboard block.
//   master : requesters, issue logic and hazard query (drive requests, see results)
//   slave  : wb_scoreboard_arb itself
//   Signals:
//     ex_*    execute-stage write-back request (valid/rd/data) and ready
//     ld_*    load-unit write-back request (valid/rd/data) and ready
//     regwren_o/rd_o/datawb_o  register-file write port
//     issue_* instruction issue (marks rd pending)
//     chk_*   hazard query, answered by stall_o
//     err_o   sticky protocol-violation flag
interface wb_scoreboard_arb_if #(parameter int DWIDTH = 32);
  logic              ex_valid_i;
  logic [4:0]        ex_rd_i;
  logic [DWIDTH-1:0] ex_data_i;
  logic              ex_ready_o;
  logic              ld_valid_i;
  logic [4:0]        ld_rd_i;
  logic [DWIDTH-1:0] ld_data_i;
  logic              ld_ready_o;
  logic              regwren_o;
  logic [4:0]        rd_o;
  logic [DWIDTH-1:0] datawb_o;
  logic              issue_valid_i;
  logic [4:0]        issue_rd_i;
  logic [4:0]        chk_rs1_i;
  logic [4:0]        chk_rs2_i;
  logic [4:0]        chk_rd_i;
  logic              chk_use1_i;
  logic              chk_use2_i;
  logic              chk_usedst_i;
  logic              stall_o;
  logic              err_o;

  modport master (
    output ex_valid_i, ex_rd_i, ex_data_i, ld_valid_i, ld_rd_i, ld_data_i,
           issue_valid_i, issue_rd_i, chk_rs1_i, chk_rs2_i, chk_rd_i,
           chk_use1_i, chk_use2_i, chk_usedst_i,
    input  ex_ready_o, ld_ready_o, regwren_o, rd_o, datawb_o, stall_o, err_o
  );

  modport slave (
    input  ex_valid_i, ex_rd_i, ex_data_i, ld_valid_i, ld_rd_i, ld_data_i,
           issue_valid_i, issue_rd_i, chk_rs1_i, chk_rs2_i, chk_rd_i,
           chk_use1_i, chk_use2_i, chk_usedst_i,
    output ex_ready_o, ld_ready_o, regwren_o, rd_o, datawb_o, stall_o, err_o
  );
endinterface

// File: rtl/wb_scoreboard_arb.sv
// wb_scoreboard_arb
//   Two-port write-back arbiter (execute vs load) with a round-robin tie
//   break, one-cycle registered register-file write port, and a 32-entry
//   pending-write scoreboard for hazard stalls.
//   Ports:
//     clk  clock, rising edge
//     rst  asynchronous reset, active low
//     bus  wb_scoreboard_arb_if.slave (requests, write port, issue, query, err)
module wb_scoreboard_arb #(
  parameter int DWIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  wb_scoreboard_arb_if.slave  bus
);

  logic              prio_q, prio_d;
  logic              regwren_q, regwren_d;
  logic [4:0]        rd_q, rd_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [31:0]       pending_q, pending_d;
  logic              err_q, err_d;

  logic              ex_gnt, ld_gnt, acc, conflict, stall;
  logic [4:0]        acc_rd;
  logic [DWIDTH-1:0] acc_data;
  logic [31:0]       set_mask, clr_mask;

  always_comb begin
    conflict = bus.ex_valid_i & bus.ld_valid_i;
    // rst gates the grants so ready is low throughout reset
    ex_gnt   = rst & bus.ex_valid_i & (~bus.ld_valid_i | ~prio_q);
    ld_gnt   = rst & bus.ld_valid_i & (~bus.ex_valid_i | prio_q);
    acc      = ex_gnt | ld_gnt;
    acc_rd   = ld_gnt ? bus.ld_rd_i   : bus.ex_rd_i;
    acc_data = ld_gnt ? bus.ld_data_i : bus.ex_data_i;

    // after a conflict, favour whichever port just lost
    prio_d = prio_q;
    if (conflict && acc) prio_d = ex_gnt;

    // x0 writes are accepted but never reach the register file
    regwren_d = acc && (acc_rd != 5'd0);
    rd_d      = regwren_d ? acc_rd   : rd_q;
    data_d    = regwren_d ? acc_data : data_q;

    set_mask = '0;
    if (bus.issue_valid_i && (bus.issue_rd_i != 5'd0)) set_mask[bus.issue_rd_i] = 1'b1;
    clr_mask = '0;
    if (regwren_q) clr_mask[rd_q] = 1'b1;
    // clear is applied first so a same-cycle issue keeps the bit set
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'h1;

    stall = (bus.chk_use1_i   & pending_q[bus.chk_rs1_i]) |
            (bus.chk_use2_i   & pending_q[bus.chk_rs2_i]) |
            (bus.chk_usedst_i & pending_q[bus.chk_rd_i]);

    err_d = err_q | (bus.issue_valid_i & stall) | (regwren_d & ~pending_q[acc_rd]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q    <= 1'b0;
      regwren_q <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      regwren_q <= regwren_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign bus.ex_ready_o = ex_gnt;
  assign bus.ld_ready_o = ld_gnt;
  assign bus.regwren_o  = regwren_q;
  assign bus.rd_o       = rd_q;
  assign bus.datawb_o   = data_q;
  assign bus.stall_o    = stall;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_wb_scoreboard_arb.sv
module tb_wb_scoreboard_arb;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_scoreboard_arb_if #(.DWIDTH(32)) bus ();

  wb_scoreboard_arb #(.DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are then sampled 1 unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.ex_valid_i = 1'b0; bus.ex_rd_i = '0; bus.ex_data_i = '0;
    bus.ld_valid_i = 1'b0; bus.ld_rd_i = '0; bus.ld_data_i = '0;
    bus.issue_valid_i = 1'b0; bus.issue_rd_i = '0;
    bus.chk_rs1_i = '0; bus.chk_rs2_i = '0; bus.chk_rd_i = '0;
    bus.chk_use1_i = 1'b0; bus.chk_use2_i = 1'b0; bus.chk_usedst_i = 1'b0;

    // reset state, ready held low even with a valid request
    #3;
    bus.ex_valid_i = 1'b1;
    #1;
    check_eq("rst_ex_ready", bus.ex_ready_o, 0);
    check_eq("rst_regwren", bus.regwren_o, 0);
    check_eq("rst_rd", bus.rd_o, 0);
    check_eq("rst_data", bus.datawb_o, 0);
    check_eq("rst_err", bus.err_o, 0);
    bus.ex_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // single EX write to x5
    cyc(); bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd5;
    cyc(); bus.issue_valid_i = 1'b0;
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd5; bus.ex_data_i = 32'hA5A55A5A;
    #1;
    check_eq("ex1_ready", bus.ex_ready_o, 1);
    check_eq("ex1_ld_ready", bus.ld_ready_o, 0);
    cyc(); bus.ex_valid_i = 1'b0;
    check_eq("ex1_wren", bus.regwren_o, 1);
    check_eq("ex1_rd", bus.rd_o, 5);
    check_eq("ex1_data", bus.datawb_o, 32'hA5A55A5A);
    cyc();
    check_eq("ex1_wren_off", bus.regwren_o, 0);

    // conflict: expected grant order ex, ld, ex
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd4;
    cyc(); bus.issue_rd_i = 5'd3;
    cyc();
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd3; bus.ex_data_i = 32'h11;
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd4; bus.ld_data_i = 32'h22;
    #1;
    check_eq("cf_t0_ex_ready", bus.ex_ready_o, 1);
    check_eq("cf_t0_ld_ready", bus.ld_ready_o, 0);
    cyc(); bus.ex_data_i = 32'h12;
    check_eq("cf_t1_wren", bus.regwren_o, 1);
    check_eq("cf_t1_rd", bus.rd_o, 3);
    check_eq("cf_t1_data", bus.datawb_o, 32'h11);
    check_eq("cf_t1_ld_ready", bus.ld_ready_o, 1);
    check_eq("cf_t1_ex_ready", bus.ex_ready_o, 0);
    cyc(); bus.ld_data_i = 32'h23;
    check_eq("cf_t2_wren", bus.regwren_o, 1);
    check_eq("cf_t2_rd", bus.rd_o, 4);
    check_eq("cf_t2_data", bus.datawb_o, 32'h22);
    check_eq("cf_t2_ex_ready", bus.ex_ready_o, 1);
    cyc();
    bus.ex_valid_i = 1'b0; bus.ld_valid_i = 1'b0; bus.issue_valid_i = 1'b0;
    check_eq("cf_t3_wren", bus.regwren_o, 1);
    check_eq("cf_t3_rd", bus.rd_o, 3);
    check_eq("cf_t3_data", bus.datawb_o, 32'h12);
    cyc();
    check_eq("cf_t4_wren", bus.regwren_o, 0);
    check_eq("cf_err", bus.err_o, 0);

    // x0 write on ld (uncontested, prio stays 1)
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd0; bus.ld_data_i = 32'hDEADBEEF;
    #1;
    check_eq("x0_ld_ready", bus.ld_ready_o, 1);
    cyc(); bus.ld_valid_i = 1'b0;
    check_eq("x0_wren", bus.regwren_o, 0);
    check_eq("x0_rd_hold", bus.rd_o, 3);
    check_eq("x0_data_hold", bus.datawb_o, 32'h12);
    check_eq("x0_err", bus.err_o, 0);

    // prio left at 1 by the last conflict: ld wins, then ex
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd0;
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd0;
    #1;
    check_eq("pr_ld_first", bus.ld_ready_o, 1);
    check_eq("pr_ex_wait", bus.ex_ready_o, 0);
    cyc(); bus.ld_valid_i = 1'b0;
    check_eq("pr_ex_next", bus.ex_ready_o, 1);
    check_eq("pr_wren0", bus.regwren_o, 0);
    cyc(); bus.ex_valid_i = 1'b0;

    // scoreboard stall release timing on x7
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd7;
    cyc(); bus.issue_valid_i = 1'b0;
    bus.chk_rs1_i = 5'd7; bus.chk_use1_i = 1'b1;
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd7; bus.ex_data_i = 32'h77;
    #1;
    check_eq("sb_stall_t0", bus.stall_o, 1);
    check_eq("sb_ex_ready", bus.ex_ready_o, 1);
    cyc(); bus.ex_valid_i = 1'b0;
    check_eq("sb_stall_t1", bus.stall_o, 1);
    check_eq("sb_wren_t1", bus.regwren_o, 1);
    cyc();
    check_eq("sb_stall_t2", bus.stall_o, 0);
    bus.chk_use1_i = 1'b0;

    // rs2 and rd query paths on x8
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd8;
    cyc(); bus.issue_valid_i = 1'b0;
    bus.chk_rd_i = 5'd8; bus.chk_usedst_i = 1'b1;
    #1;
    check_eq("sb_dst", bus.stall_o, 1);
    bus.chk_usedst_i = 1'b0; bus.chk_rs2_i = 5'd8; bus.chk_use2_i = 1'b1;
    #1;
    check_eq("sb_rs2", bus.stall_o, 1);
    bus.chk_use2_i = 1'b0;
    #1;
    check_eq("sb_nouse", bus.stall_o, 0);

    // same-cycle set/clear on x9, then issue under stall
    cyc(); bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd9;
    cyc(); bus.issue_valid_i = 1'b0;
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd9; bus.ex_data_i = 32'h99;
    cyc(); bus.ex_valid_i = 1'b0;
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd9;
    check_eq("sc_wren", bus.regwren_o, 1);
    check_eq("sc_rd", bus.rd_o, 9);
    cyc(); bus.issue_valid_i = 1'b0;
    bus.chk_rs1_i = 5'd9; bus.chk_use1_i = 1'b1;
    #1;
    check_eq("sc_set_wins", bus.stall_o, 1);
    check_eq("sc_err_before", bus.err_o, 0);
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd10;
    cyc(); bus.issue_valid_i = 1'b0;
    check_eq("sc_err_set", bus.err_o, 1);
    bus.chk_use1_i = 1'b0;
    cyc();
    check_eq("sc_err_sticky", bus.err_o, 1);

    // reset while a write is registered
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd11;
    cyc(); bus.issue_valid_i = 1'b0;
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd11; bus.ex_data_i = 32'hBB;
    cyc(); bus.ex_valid_i = 1'b0;
    check_eq("rm_wren_before", bus.regwren_o, 1);
    #1 rst = 1'b0;
    #1;
    check_eq("rm_wren_async", bus.regwren_o, 0);
    check_eq("rm_data_async", bus.datawb_o, 0);
    check_eq("rm_err_clr", bus.err_o, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.chk_rs1_i = 5'd8; bus.chk_use1_i = 1'b1;
    bus.chk_rs2_i = 5'd9; bus.chk_use2_i = 1'b1;
    bus.chk_rd_i = 5'd11; bus.chk_usedst_i = 1'b1;
    #1;
    check_eq("rm_pending_clr", bus.stall_o, 0);
    bus.chk_use1_i = 1'b0; bus.chk_use2_i = 1'b0; bus.chk_usedst_i = 1'b0;

    // first edge after release accepts; unissued nonzero write flags err
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd12; bus.ex_data_i = 32'hCC;
    #1;
    check_eq("rel_ex_ready", bus.ex_ready_o, 1);
    cyc(); bus.ex_valid_i = 1'b0;
    check_eq("rel_wren", bus.regwren_o, 1);
    check_eq("rel_data", bus.datawb_o, 32'hCC);
    check_eq("unpend_err", bus.err_o, 1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
